// File: rtl/i2c_slave_regs.sv
// rtl/i2c_slave_regs.sv - I2C target exposing a synchronous register port (write/burst write/read)
module i2c_slave_regs #(
    parameter logic [7:0] SLAVE_ADDR = 8'h72,
    parameter int         ADDR_W     = 8
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              I2C_SCLK,
    inout  wire               I2C_SDAT,
    output logic [ADDR_W-1:0] REG_ADDR,
    output logic [7:0]        REG_WDATA,
    output logic              REG_WE,
    input  logic [7:0]        REG_RDATA,
    output logic              BUSY
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_SUB,
        S_SUB_ACK,
        S_WDATA,
        S_WDATA_ACK,
        S_RDATA,
        S_RDATA_ACK,
        S_NACK_WAIT
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [2:0]        scl_sync_q, sda_sync_q;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [6:0]        shift_q, shift_d;
    logic [6:0]        tx_q, tx_d;
    logic              sda_oe_q, sda_oe_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
    logic [7:0]        reg_wdata_q, reg_wdata_d;
    logic              reg_we_q, reg_we_d;
    logic              busy_q, busy_d;

    // Stage 2 is the current level, stage 3 the previous one; their difference is an edge.
    logic       scl_rise, scl_fall, sda_lvl, start_det, stop_det, byte_done;
    logic [7:0] rx_byte;

    assign scl_rise  = scl_sync_q[1] & ~scl_sync_q[2];
    assign scl_fall  = ~scl_sync_q[1] & scl_sync_q[2];
    assign sda_lvl   = sda_sync_q[1];
    assign start_det = scl_sync_q[1] & scl_sync_q[2] & sda_sync_q[2] & ~sda_sync_q[1];
    assign stop_det  = scl_sync_q[1] & scl_sync_q[2] & ~sda_sync_q[2] & sda_sync_q[1];
    assign rx_byte   = {shift_q, sda_lvl};
    assign byte_done = scl_rise && (bit_cnt_q == 4'd7);

    // Open-drain: only ever pull low or release.
    assign I2C_SDAT  = sda_oe_q ? 1'b0 : 1'bz;
    assign REG_ADDR  = reg_addr_q;
    assign REG_WDATA = reg_wdata_q;
    assign REG_WE    = reg_we_q;
    assign BUSY      = busy_q;

    // Synchronizers and all protocol state; idle bus level is high so reset to 1s.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            scl_sync_q  <= 3'b111;
            sda_sync_q  <= 3'b111;
            state_q     <= S_IDLE;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 7'd0;
            tx_q        <= 7'd0;
            sda_oe_q    <= 1'b0;
            rw_q        <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= 8'd0;
            reg_we_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            scl_sync_q  <= {scl_sync_q[1:0], I2C_SCLK};
            sda_sync_q  <= {sda_sync_q[1:0], I2C_SDAT};
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            sda_oe_q    <= sda_oe_d;
            rw_q        <= rw_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_we_q    <= reg_we_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state logic: bus START/STOP override everything, then per-state bit handling.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        sda_oe_d    = sda_oe_q;
        rw_d        = rw_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_we_d    = 1'b0;
        busy_d      = busy_q;

        if (start_det) begin
            state_d   = S_ADDR;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
        end else if (stop_det) begin
            state_d   = S_IDLE;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                S_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte[6:0];
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                    if (byte_done) begin
                        bit_cnt_d = 4'd0;
                        if (rx_byte[7:1] == SLAVE_ADDR[7:1]) begin
                            state_d = S_ADDR_ACK;
                            busy_d  = 1'b1;
                            rw_d    = rx_byte[0];
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                S_SUB: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte[6:0];
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                    if (byte_done) begin
                        bit_cnt_d  = 4'd0;
                        reg_addr_d = rx_byte[ADDR_W-1:0];
                        state_d    = S_SUB_ACK;
                    end
                end
                S_WDATA: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte[6:0];
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                    if (byte_done) begin
                        bit_cnt_d   = 4'd0;
                        reg_wdata_d = rx_byte;
                        reg_we_d    = 1'b1;
                        state_d     = S_WDATA_ACK;
                    end
                end
                // First SCL fall starts the ACK pull-down, the second one ends it.
                S_ADDR_ACK, S_SUB_ACK, S_WDATA_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 4'd0;
                            if (state_q == S_ADDR_ACK && rw_q) begin
                                tx_d     = REG_RDATA[6:0];
                                sda_oe_d = ~REG_RDATA[7];
                                state_d  = S_RDATA;
                            end else if (state_q == S_ADDR_ACK) begin
                                state_d = S_SUB;
                            end else if (state_q == S_SUB_ACK) begin
                                state_d = S_WDATA;
                            end else begin
                                reg_addr_d = reg_addr_q + ADDR_ONE;
                                state_d    = S_WDATA;
                            end
                        end
                    end
                end
                // Bit 7 is already on the bus; counter counts rises so 8 means the byte is out.
                S_RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 4'd0;
                            state_d   = S_RDATA_ACK;
                        end else begin
                            sda_oe_d = ~tx_q[6];
                            tx_d     = {tx_q[5:0], 1'b0};
                        end
                    end
                end
                // bit_cnt_q==1 marks "master ACKed, pointer bumped, load on next fall".
                S_RDATA_ACK: begin
                    if (scl_rise) begin
                        if (sda_lvl) begin
                            state_d = S_NACK_WAIT;
                        end else begin
                            reg_addr_d = reg_addr_q + ADDR_ONE;
                            bit_cnt_d  = 4'd1;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd1) begin
                        tx_d      = REG_RDATA[6:0];
                        sda_oe_d  = ~REG_RDATA[7];
                        bit_cnt_d = 4'd0;
                        state_d   = S_RDATA;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave_regs.sv
// tb/tb_i2c_slave_regs.sv - randomized self-checking bench for i2c_slave_regs
module tb_i2c_slave_regs;

    localparam int Q = 6;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scl;
    logic       m_sda_oe;
    wire        sda_bus;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic [7:0] reg_rdata;
    logic       busy;

    int total = 0;
    int bad   = 0;

    logic [15:0] wr_q[$];
    logic [15:0] exp_q[$];
    logic        slave_drove;
    logic [7:0]  model_ptr;

    always #5 clk = ~clk;

    pullup (sda_bus);
    assign sda_bus   = m_sda_oe ? 1'b0 : 1'bz;
    assign reg_rdata = reg_addr ^ 8'h5A;

    i2c_slave_regs #(.SLAVE_ADDR(8'h72), .ADDR_W(8)) dut (
        .iCLK      (clk),
        .iRST_N    (rst_n),
        .I2C_SCLK  (scl),
        .I2C_SDAT  (sda_bus),
        .REG_ADDR  (reg_addr),
        .REG_WDATA (reg_wdata),
        .REG_WE    (reg_we),
        .REG_RDATA (reg_rdata),
        .BUSY      (busy)
    );

    always @(negedge clk) begin
        if (reg_we === 1'b1) wr_q.push_back({reg_addr, reg_wdata});
        if (!m_sda_oe && sda_bus === 1'b0) slave_drove <= 1'b1;
    end

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_sda_oe = 1'b0; wait_q();
        scl = 1'b1;      wait_q();
        m_sda_oe = 1'b1; wait_q();
        scl = 1'b0;      wait_q();
    endtask

    task automatic i2c_stop();
        m_sda_oe = 1'b1; wait_q();
        scl = 1'b1;      wait_q();
        m_sda_oe = 1'b0; wait_q();
        wait_q();
    endtask

    task automatic write_bit(input logic b);
        m_sda_oe = ~b; wait_q();
        scl = 1'b1;    wait_q(); wait_q();
        scl = 1'b0;    wait_q();
    endtask

    task automatic read_bit(output logic b);
        m_sda_oe = 1'b0; wait_q();
        scl = 1'b1;      wait_q();
        b = sda_bus;     wait_q();
        scl = 1'b0;      wait_q();
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic rb;
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(rb);
        ack = (rb === 1'b0);
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] d);
        logic rb;
        for (int i = 7; i >= 0; i--) begin
            read_bit(rb);
            d[i] = rb;
        end
        write_bit(nack);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; scl = 1'b1; m_sda_oe = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        model_ptr = 8'h00;
        total++; if (reg_addr !== 8'h00) begin bad++; $display("FAIL reset_addr got=%h exp=00", reg_addr); end
        total++; if (reg_wdata !== 8'h00) begin bad++; $display("FAIL reset_wdata got=%h exp=00", reg_wdata); end
        total++; if (reg_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", reg_we); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (sda_bus !== 1'b1) begin bad++; $display("FAIL reset_sda got=%b exp=1", sda_bus); end
    endtask

    task automatic test_basic_write();
        logic ack;
        wr_q.delete();
        i2c_start();
        send_byte(8'h72, ack);
        total++; if (ack !== 1'b1) begin bad++; $display("FAIL bw_ack_dev got=%b exp=1", ack); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL bw_busy_mid got=%b exp=1", busy); end
        send_byte(8'h15, ack);
        total++; if (ack !== 1'b1) begin bad++; $display("FAIL bw_ack_sub got=%b exp=1", ack); end
        send_byte(8'h20, ack);
        total++; if (ack !== 1'b1) begin bad++; $display("FAIL bw_ack_data got=%b exp=1", ack); end
        i2c_stop();
        model_ptr = 8'h16;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL bw_busy_end got=%b exp=0", busy); end
        total++; if (wr_q.size() !== 1) begin bad++; $display("FAIL bw_nwr got=%0d exp=1", wr_q.size()); end
        else begin
            total++; if (wr_q[0] !== 16'h1520) begin bad++; $display("FAIL bw_wr got=%h exp=1520", wr_q[0]); end
        end
        total++; if (reg_addr !== model_ptr) begin bad++; $display("FAIL bw_ptr got=%h exp=%h", reg_addr, model_ptr); end
    endtask

    task automatic test_wrong_addr();
        logic ack;
        logic [7:0] frame[3];
        frame = '{8'h34, 8'h00, 8'h17};
        wr_q.delete();
        slave_drove = 1'b0;
        i2c_start();
        for (int i = 0; i < 3; i++) begin
            send_byte(frame[i], ack);
            total++; if (ack !== 1'b0) begin bad++; $display("FAIL wa_ack%0d got=%b exp=0", i, ack); end
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL wa_busy%0d got=%b exp=0", i, busy); end
        end
        i2c_stop();
        total++; if (slave_drove !== 1'b0) begin bad++; $display("FAIL wa_sda_driven got=%b exp=0", slave_drove); end
        total++; if (wr_q.size() !== 0) begin bad++; $display("FAIL wa_nwr got=%0d exp=0", wr_q.size()); end
        total++; if (reg_addr !== model_ptr) begin bad++; $display("FAIL wa_ptr got=%h exp=%h", reg_addr, model_ptr); end
    endtask

    task automatic test_burst();
        logic ack;
        logic [7:0] data[3];
        logic [7:0] p;
        data = '{8'hA1, 8'hB2, 8'hC3};
        wr_q.delete(); exp_q.delete();
        i2c_start();
        send_byte(8'h72, ack);
        send_byte(8'hFE, ack);
        p = 8'hFE;
        for (int i = 0; i < 3; i++) begin
            send_byte(data[i], ack);
            total++; if (ack !== 1'b1) begin bad++; $display("FAIL bu_ack%0d got=%b exp=1", i, ack); end
            exp_q.push_back({p, data[i]});
            p = p + 8'd1;
        end
        i2c_stop();
        model_ptr = p;
        total++; if (wr_q.size() !== exp_q.size()) begin bad++; $display("FAIL bu_nwr got=%0d exp=%0d", wr_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
            total++; if (wr_q[i] !== exp_q[i]) begin bad++; $display("FAIL bu_wr%0d got=%h exp=%h", i, wr_q[i], exp_q[i]); end
        end
        total++; if (reg_addr !== model_ptr) begin bad++; $display("FAIL bu_ptr got=%h exp=%h", reg_addr, model_ptr); end
    endtask

    task automatic test_read();
        logic ack;
        logic [7:0] d;
        logic [7:0] p;
        wr_q.delete();
        i2c_start();
        send_byte(8'h72, ack);
        send_byte(8'h40, ack);
        i2c_start();
        send_byte(8'h73, ack);
        total++; if (ack !== 1'b1) begin bad++; $display("FAIL rd_ack_dev got=%b exp=1", ack); end
        p = 8'h40;
        for (int i = 0; i < 3; i++) begin
            recv_byte(i == 2, d);
            total++; if (d !== (p ^ 8'h5A)) begin bad++; $display("FAIL rd_byte%0d got=%h exp=%h", i, d, p ^ 8'h5A); end
            if (i < 2) p = p + 8'd1;
        end
        model_ptr = p;
        total++; if (sda_bus !== 1'b1) begin bad++; $display("FAIL rd_sda_rel got=%b exp=1", sda_bus); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rd_busy_nack got=%b exp=1", busy); end
        total++; if (reg_addr !== 8'h42) begin bad++; $display("FAIL rd_ptr got=%h exp=42", reg_addr); end
        i2c_stop();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rd_busy_end got=%b exp=0", busy); end
        total++; if (wr_q.size() !== 0) begin bad++; $display("FAIL rd_nwr got=%0d exp=0", wr_q.size()); end
    endtask

    task automatic test_abort();
        logic ack;
        wr_q.delete();
        i2c_start();
        send_byte(8'h72, ack);
        send_byte(8'h5C, ack);
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
        i2c_stop();
        model_ptr = 8'h5C;
        total++; if (wr_q.size() !== 0) begin bad++; $display("FAIL ab_nwr got=%0d exp=0", wr_q.size()); end
        total++; if (reg_addr !== model_ptr) begin bad++; $display("FAIL ab_ptr got=%h exp=%h", reg_addr, model_ptr); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ab_busy got=%b exp=0", busy); end
        i2c_start();
        send_byte(8'h72, ack);
        send_byte(8'h60, ack);
        send_byte(8'h99, ack);
        total++; if (ack !== 1'b1) begin bad++; $display("FAIL ab_ack_after got=%b exp=1", ack); end
        i2c_stop();
        model_ptr = 8'h61;
        total++; if (wr_q.size() !== 1) begin bad++; $display("FAIL ab_nwr_after got=%0d exp=1", wr_q.size()); end
        else begin
            total++; if (wr_q[0] !== 16'h6099) begin bad++; $display("FAIL ab_wr_after got=%h exp=6099", wr_q[0]); end
        end
    endtask

    task automatic test_reset_mid();
        logic ack;
        logic rb;
        i2c_start();
        for (int i = 7; i >= 0; i--) write_bit(logic'((8'h72 >> i) & 8'h01));
        m_sda_oe = 1'b0; wait_q();
        scl = 1'b1;      wait_q();
        total++; if (sda_bus !== 1'b0) begin bad++; $display("FAIL rm_ack_low got=%b exp=0", sda_bus); end
        rst_n = 1'b0;
        #1;
        total++; if (sda_bus !== 1'b1) begin bad++; $display("FAIL rm_sda_rel got=%b exp=1", sda_bus); end
        total++; if ({reg_addr, reg_wdata, reg_we, busy} !== 18'h0) begin
            bad++; $display("FAIL rm_outs got=%h/%h/%b/%b exp=0", reg_addr, reg_wdata, reg_we, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_ptr = 8'h00;
        wait_q();
        scl = 1'b0; wait_q();
        i2c_stop();
        wr_q.delete();
        i2c_start();
        send_byte(8'h72, ack);
        total++; if (ack !== 1'b1) begin bad++; $display("FAIL rm_ack_dev got=%b exp=1", ack); end
        send_byte(8'h01, ack);
        send_byte(8'h02, ack);
        total++; if (ack !== 1'b1) begin bad++; $display("FAIL rm_ack_data got=%b exp=1", ack); end
        i2c_stop();
        model_ptr = 8'h02;
        total++; if (wr_q.size() !== 1) begin bad++; $display("FAIL rm_nwr got=%0d exp=1", wr_q.size()); end
        else begin
            total++; if (wr_q[0] !== 16'h0102) begin bad++; $display("FAIL rm_wr got=%h exp=0102", wr_q[0]); end
        end
        total++; if (reg_addr !== model_ptr) begin bad++; $display("FAIL rm_ptr got=%h exp=%h", reg_addr, model_ptr); end
    endtask

    task automatic test_random();
        logic       ack, match, is_read;
        logic [7:0] dev, sub, dat, d;
        int         n;
        for (int it = 0; it < 14; it++) begin
            dev = 8'h72;
            if ($urandom_range(0, 3) == 0) begin
                dev = 8'($urandom);
                if (dev[7:1] == 7'h39) dev = dev ^ 8'h80;
            end
            dev[0]  = 1'b0;
            match   = (dev[7:1] == 7'h39);
            is_read = ($urandom_range(0, 2) == 0);
            sub     = 8'($urandom);
            n       = $urandom_range(is_read ? 1 : 0, 3);
            wr_q.delete(); exp_q.delete();
            i2c_start();
            send_byte(dev, ack);
            total++; if (ack !== match) begin bad++; $display("FAIL rnd%0d_ack_dev got=%b exp=%b", it, ack, match); end
            send_byte(sub, ack);
            if (match) model_ptr = sub;
            if (!is_read) begin
                for (int k = 0; k < n; k++) begin
                    dat = 8'($urandom);
                    send_byte(dat, ack);
                    total++; if (ack !== match) begin bad++; $display("FAIL rnd%0d_ack_w%0d got=%b exp=%b", it, k, ack, match); end
                    if (match) begin
                        exp_q.push_back({model_ptr, dat});
                        model_ptr = model_ptr + 8'd1;
                    end
                end
            end else begin
                i2c_start();
                send_byte(dev | 8'h01, ack);
                total++; if (ack !== match) begin bad++; $display("FAIL rnd%0d_ack_rd got=%b exp=%b", it, ack, match); end
                if (match) begin
                    for (int k = 0; k < n; k++) begin
                        recv_byte(k == n - 1, d);
                        total++; if (d !== (model_ptr ^ 8'h5A)) begin bad++; $display("FAIL rnd%0d_rd%0d got=%h exp=%h", it, k, d, model_ptr ^ 8'h5A); end
                        if (k < n - 1) model_ptr = model_ptr + 8'd1;
                    end
                end
            end
            i2c_stop();
            total++; if (wr_q.size() !== exp_q.size()) begin bad++; $display("FAIL rnd%0d_nwr got=%0d exp=%0d", it, wr_q.size(), exp_q.size()); end
            for (int k = 0; k < exp_q.size() && k < wr_q.size(); k++) begin
                total++; if (wr_q[k] !== exp_q[k]) begin bad++; $display("FAIL rnd%0d_wr%0d got=%h exp=%h", it, k, wr_q[k], exp_q[k]); end
            end
            total++; if (reg_addr !== model_ptr) begin bad++; $display("FAIL rnd%0d_ptr got=%h exp=%h", it, reg_addr, model_ptr); end
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL rnd%0d_busy got=%b exp=0", it, busy); end
        end
    endtask

    initial begin
        slave_drove = 1'b0;
        test_reset();
        test_basic_write();
        test_wrong_addr();
        test_burst();
        test_read();
        test_abort();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2c_slave_regs.md
Name: i2c_slave_regs

Overview:
- I2C target (responder) for the config bus. It decodes the same 3-byte write frame that the board's I2C config master issues: slave address, sub-address, data.
- Exposes a simple synchronous register-port so on-chip logic (test shadow registers, a soft codec/HDMI model in sim) can be configured over I2C.
- Also supports register reads via repeated START.
- Runs on the system clock and oversamples SCL/SDA; there is no clock-domain crossing other than the input synchronizers.

Parameters:
- SLAVE_ADDR, 8'h72, 8-bit write-form device address; only bits [7:1] are compared, bit 0 is R/W.
- ADDR_W, 8, sub-address/register pointer width.

Ports:
- iCLK  input  1  system clock (≥ 20× SCL rate).
- iRST_N  input  1  asynchronous active-low reset.
- I2C_SCLK  input  1  I2C clock from master.
- I2C_SDAT  inout  1  I2C data, open-drain: driven 0 or Z only.
- REG_ADDR  output  ADDR_W  current register pointer.
- REG_WDATA  output  8  write data byte.
- REG_WE  output  1  one-cycle write strobe.
- REG_RDATA  input  8  read data for REG_ADDR, combinational, valid same cycle.
- BUSY  output  1  high from an address-matched START until STOP.

Behaviour:
- Reset values: REG_ADDR=0, REG_WDATA=0, REG_WE=0, BUSY=0, SDA released (Z), state IDLE.
- Input sync:
  - SCL and SDA each pass through 3 flops. Stages 2/3 give level and edge.
  - Fixed 2-cycle detection latency.
- Bus condition detection (evaluated in every state, highest priority):
  - START: SDA fall while SCL high.
  - STOP: SDA rise while SCL high.
- START (including repeated START): go to ADDR, clear bit counter, release SDA.
- STOP: go to IDLE, release SDA, BUSY=0.
- Data bits are sampled on SCL rising edge, MSB first. Bit counter runs 0..7.
- SDA is changed only on the SCL falling edge.
- States:
  - IDLE: wait for START.
  - ADDR:
    - After 8 bits, compare [7:1] with SLAVE_ADDR[7:1].
    - Mismatch → IDLE, no ACK, no outputs touched.
    - Match → ADDR_ACK, BUSY=1, latch RW bit.
  - ADDR_ACK:
    - Drive SDA=0 from the next SCL fall to the following SCL fall, then release.
    - Next state: RW=0 → SUB; RW=1 → RDATA.
  - SUB:
    - After 8 bits, load the byte into REG_ADDR (low ADDR_W bits).
    - ACK as above, then WDATA.
  - WDATA:
    - On the 8th rising edge, set REG_WDATA=byte and pulse REG_WE for exactly 1 iCLK with the current REG_ADDR.
    - ACK, then increment REG_ADDR at the ACK-release SCL fall. Wraps at 2^ADDR_W.
    - Remain in WDATA for burst writes.
  - RDATA:
    - At the SCL fall that ends the ACK, latch REG_RDATA into the TX shift register.
    - Drive bit 7, then shift one bit per SCL fall; a 1 bit is released as Z.
    - After the 8th bit, release SDA and go to RDATA_ACK.
  - RDATA_ACK:
    - Sample SDA on SCL rise.
    - 0 (ACK): increment REG_ADDR (wrapping) and return to RDATA.
    - 1 (NACK): go to IDLE-wait. SDA stays released; BUSY stays 1 until STOP or START.
- Write sequence decided: a read after a write-with-sub-address-only then repeated START returns the register at that sub-address.
- STOP or START mid-byte: abort the byte with no REG_WE, keep REG_ADDR, release SDA immediately (within 1 iCLK of detection).
- Reset mid-transfer: all outputs return to reset values asynchronously, SDA released. The bus recovers on the next START.
- The master retries on NACK; the slave treats every START identically, so retries need no special handling.

Test Plan:
- Write 0x72,0x15,0x20,STOP → ACK on all 3 bytes; one REG_WE pulse with REG_ADDR=0x15, REG_WDATA=0x20; BUSY 1→0 at STOP.
- Write to address 0x34 with bytes 0x00,0x17 → SDA never driven, no REG_WE, BUSY stays 0.
- Burst write 0x72,0xFE,0xA1,0xB2,0xC3 → REG_WE at 0xFE/A1, 0xFF/B2, 0x00/C3 (wrap).
- Read:
  - Stimulus: 0x72,0x40, repeated START, 0x73; REG_RDATA model returns addr^0x5A; master ACKs 2 bytes then NACKs the third.
  - Response: SDA carries 0x1A, 0x1B, 0x18; REG_ADDR ends at 0x42; SDA released after NACK.
- STOP inserted after 4 data bits of WDATA → no REG_WE, REG_ADDR unchanged. A following full frame writes correctly.
- iRST_N asserted during ADDR_ACK (SDA low) → SDA released within the same cycle, all outputs 0. A following 0x72,0x01,0x02 frame is ACKed and writes.
